// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM / one-shot pulse generator. Each channel has double-buffered
// period/duty/mode settings that switch over only in IDLE or on the last cycle of a period.
module pwm_gen_multi #(
  parameter int unsigned CH    = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH_W  = 4
) (
  input  logic             i_clk50,
  input  logic             i_rst_n,
  input  logic [CH-1:0]    i_en,
  input  logic             i_cfg_we,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [WIDTH-1:0] i_cfg_period,
  input  logic [WIDTH-1:0] i_cfg_duty,
  input  logic             i_cfg_mode,
  output logic             o_cfg_ack,
  output logic [CH-1:0]    o_pwm,
  output logic [CH-1:0]    o_tick,
  output logic [CH-1:0]    o_done,
  output logic [CH-1:0]    o_busy
);

  typedef struct packed {
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] duty;
    logic             mode;
  } cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  cfg_t w_cfg_in;
  logic w_ch_valid;
  logic r_cfg_ack;

  assign w_cfg_in   = {i_cfg_period, i_cfg_duty, i_cfg_mode};
  assign w_ch_valid = (32'(i_cfg_ch) < CH);

  // Acknowledge only writes that target an existing channel
  always_ff @(posedge i_clk50 or negedge i_rst_n) begin
    if (!i_rst_n) r_cfg_ack <= 1'b0;
    else          r_cfg_ack <= i_cfg_we && w_ch_valid;
  end

  assign o_cfg_ack = r_cfg_ack;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    cfg_t             r_act, w_act_nxt;
    cfg_t             r_shd, w_shd_nxt;
    cfg_t             w_shd_eff;
    logic             r_pend, w_pend_nxt;
    logic             w_wr, w_at_end, w_load;
    logic             r_pwm, r_tick, r_done, r_busy;
    logic             w_pwm_nxt, w_tick_nxt, w_done_nxt;

    assign w_wr      = i_cfg_we && (32'(i_cfg_ch) == 32'(g));
    // A write in the same cycle as a boundary is forwarded straight to the active set
    assign w_shd_eff = w_wr ? w_cfg_in : r_shd;
    assign w_at_end  = (r_cnt == r_act.period);

    always_ff @(posedge i_clk50 or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_act   <= '0;
        r_shd   <= '0;
        r_pend  <= 1'b0;
        r_pwm   <= 1'b0;
        r_tick  <= 1'b0;
        r_done  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_act   <= w_act_nxt;
        r_shd   <= w_shd_nxt;
        r_pend  <= w_pend_nxt;
        r_pwm   <= w_pwm_nxt;
        r_tick  <= w_tick_nxt;
        r_done  <= w_done_nxt;
        r_busy  <= (w_state_nxt == ST_RUN);
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_act_nxt   = r_act;
      w_shd_nxt   = w_shd_eff;
      w_pend_nxt  = r_pend | w_wr;
      w_load      = 1'b0;
      w_pwm_nxt   = 1'b0;
      w_tick_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          w_load    = 1'b1;
          w_cnt_nxt = '0;
          if (i_en[g]) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!i_en[g]) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_pwm_nxt = (r_cnt < r_act.duty);
            if (w_at_end) begin
              w_tick_nxt = 1'b1;
              w_load     = 1'b1;
              w_cnt_nxt  = '0;
              if (r_act.mode) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_HOLD;
              end
            end else begin
              w_cnt_nxt = r_cnt + WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          w_cnt_nxt = '0;
          if (!i_en[g]) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
      if (w_load && (r_pend || w_wr)) begin
        w_act_nxt  = w_shd_eff;
        w_pend_nxt = 1'b0;
      end
    end

    assign o_pwm[g]  = r_pwm;
    assign o_tick[g] = r_tick;
    assign o_done[g] = r_done;
    assign o_busy[g] = r_busy;
  end

endmodule
